hazard_scoreboard: RTL and testbench

Parametrised, clocked hazard detector for the ID stage. It replaces per-stage destination comparison with a per-register countdown scoreboard, so the pipeline depth and load latency are parameters rather than fixed port lists. Each issued writer loads a timer for its destination; a reader stalls while a timer on any of its valid sources is non-zero. It also reports a saturating consecutive-stall count and a busy vector for debug and perf counters.

---
 rtl/hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector built on per-register countdown timers.
// Define STATUS_HAZARD_EN to add a CPSR-flag timer with s_upd/cond_use ports.
module hazard_scoreboard #(
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int WB_DIST   = 2,
  parameter int LOAD_DIST = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              is_imm,
  input  logic              is_str,
  input  logic [ADDR_W-1:0] dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              fu_en,
`ifdef STATUS_HAZARD_EN
  input  logic              s_upd,
  input  logic              cond_use,
`endif
  output logic              hazard_detected,
  output logic [CNT_W-1:0]  stall_count,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int TW = $clog2(WB_DIST + 1);
  localparam logic [TW-1:0] WB_T = TW'(WB_DIST);
  localparam logic [TW-1:0] LD_T = TW'(LOAD_DIST);

  logic [TW-1:0]         timer_q [NUM_REGS];
  logic [TW-1:0]         timer_d [NUM_REGS];
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [2**ADDR_W-1:0]  busy_ext;
  logic                  src2_valid;
  logic                  raw_haz;
  logic                  can_issue;
  logic [TW-1:0]         ld_val;

  // A re-issue only ever extends the wait, never shortens it.
  function automatic logic [TW-1:0] nxt(
    input logic [TW-1:0] t,
    input logic          ld,
    input logic [TW-1:0] lv
  );
    logic [TW-1:0] dec;
    dec = (t != '0) ? t - 1'b1 : t;
    return (ld && lv > dec) ? lv : dec;
  endfunction

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_vec[i] = (timer_q[i] != '0);
  end

  // Out-of-range addresses map onto zero padding and never stall.
  always_comb begin
    busy_ext = '0;
    busy_ext[NUM_REGS-1:0] = busy_vec;
  end

  assign src2_valid = !is_imm || is_str;

`ifdef STATUS_HAZARD_EN
  logic [TW-1:0] st_q;
  logic [TW-1:0] st_d;

  assign raw_haz = busy_ext[src1]
                || (src2_valid && busy_ext[src2])
                || (cond_use && st_q != '0);
`else
  assign raw_haz = busy_ext[src1]
                || (src2_valid && busy_ext[src2]);
`endif

  assign hazard_detected = !flush && id_valid && raw_haz;
  assign can_issue = id_valid && !hazard_detected && !flush;

  always_comb begin
    ld_val = WB_T;
    if (fu_en)
      ld_val = mem_r_en ? LD_T : '0;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      timer_d[i] = nxt(timer_q[i],
                       can_issue && wb_en && dest == ADDR_W'(i),
                       ld_val);
      if (flush)
        timer_d[i] = '0;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (hazard_detected)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        timer_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        timer_q[i] <= timer_d[i];
      cnt_q <= cnt_d;
    end
  end

`ifdef STATUS_HAZARD_EN
  always_comb begin
    st_d = nxt(st_q, can_issue && s_upd, ld_val);
    if (flush)
      st_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end
`endif

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, monitor checks.
// A second instance with a 1-bit counter covers stall-count saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        is_imm;
  logic        is_str;
  logic [3:0]  dest;
  logic        wb_en;
  logic        mem_r_en;
  logic        fu_en;
  logic        s_upd;
  logic        cond_use;
  logic        haz;
  logic [7:0]  cnt;
  logic [15:0] busy;
  logic        haz1;
  logic [0:0]  cnt1;
  logic [15:0] busy1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      nm;
    logic       h;
    logic [15:0] b;
    int         c;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .src1(src1), .src2(src2),
    .is_imm(is_imm), .is_str(is_str), .dest(dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .fu_en(fu_en),
`ifdef STATUS_HAZARD_EN
    .s_upd(s_upd), .cond_use(cond_use),
`endif
    .hazard_detected(haz), .stall_count(cnt),
    .busy_vec(busy)
  );

  hazard_scoreboard #(.CNT_W(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .src1(src1), .src2(src2),
    .is_imm(is_imm), .is_str(is_str), .dest(dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .fu_en(fu_en),
`ifdef STATUS_HAZARD_EN
    .s_upd(s_upd), .cond_use(cond_use),
`endif
    .hazard_detected(haz1), .stall_count(cnt1),
    .busy_vec(busy1)
  );

  function automatic void chk(string nm, string f,
                              int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s.%s got %0d expected %0d",
               nm, f, act, exp);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "haz", int'(haz), int'(e.h));
        chk(e.nm, "busy", int'(busy), int'(e.b));
        chk(e.nm, "cnt", int'(cnt), e.c);
        chk(e.nm, "haz_sat", int'(haz1), int'(e.h));
        chk(e.nm, "busy_sat", int'(busy1), int'(e.b));
        chk(e.nm, "cnt_sat", int'(cnt1),
            (e.c > 1) ? 1 : e.c);
      end
    end
  end

  task automatic step(
    input string nm, input logic rst,
    input logic v, input logic [3:0] s1,
    input logic [3:0] s2, input logic imm,
    input logic str, input logic [3:0] d,
    input logic wb, input logic ld,
    input logic fu, input logic fl,
    input logic su, input logic cu,
    input logic eh, input logic [15:0] eb,
    input int ec
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; id_valid = v;
    src1 = s1; src2 = s2;
    is_imm = imm; is_str = str;
    dest = d; wb_en = wb; mem_r_en = ld;
    fu_en = fu; flush = fl;
    s_upd = su; cond_use = cu;
    e.nm = nm; e.h = eh; e.b = eb; e.c = ec;
    q.push_back(e);
  endtask

  initial begin : stim
    int guard;
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0;
    src1 = '0; src2 = '0; is_imm = 1'b0;
    is_str = 1'b0; dest = '0; wb_en = 1'b0;
    mem_r_en = 1'b0; fu_en = 1'b0;
    s_upd = 1'b0; cond_use = 1'b0;
    //   name   rst v s1 s2 im st d  wb ld fu fl su cu  h  busy    c
    step("rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("idle",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // ALU r3 without forwarding, then consumer
    step("t1c0",1, 1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("t1c1",1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0);
    step("t1c2",1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 1);
    step("t1c3",1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 2);
    step("t1c4",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // forwarded load r5 then src2 consumer
    step("t2ld",1, 1, 0, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0, 16'h0000, 0);
    step("t2c1",1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0020, 0);
    step("t2c2",1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 1);
    step("t2al",1, 1, 0, 0, 1, 0, 5, 1, 0, 1, 0, 0, 0, 0, 16'h0000, 0);
    step("t2c3",1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 0);
    // src2 validity from is_imm/is_str
    step("t3is",1, 1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("t3im",1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 0);
    step("t3st",1, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0);
    step("t3dn",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1);
    // flush clears r4 and drops the r6 issue
    step("t4is",1, 1, 0, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("t4fl",1, 1, 4, 0, 1, 0, 6, 1, 0, 0, 1, 0, 0, 0, 16'h0010, 0);
    step("t4af",1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // load then ALU to r7: timer ends at 2
    step("t5ld",1, 1, 0, 0, 1, 0, 7, 1, 1, 1, 0, 0, 0, 0, 16'h0000, 0);
    step("t5al",1, 1, 0, 0, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 16'h0080, 0);
    step("t5c1",1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0080, 0);
    step("t5c2",1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0080, 1);
    step("t5c3",1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 2);
    // async reset mid-stall
    step("t6is",1, 1, 0, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("t6c1",1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200, 0);
    step("t6rs",0, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    step("t6up",1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
`ifdef STATUS_HAZARD_EN
    // CMP then MOVEQ
    step("t7cm",1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0);
    step("t7c1",1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 0);
    step("t7c2",1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 1);
    step("t7c3",1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 2);
`endif
    step("end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain got %0d pending expected 0",
               q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
